// File: rtl/dense_wave_loader_pkg.sv
// Shared types and default geometry for the dense waveform loader.
package dense_loader_pkg;

    localparam int DEF_SAMPLE_WIDTH     = 16;
    localparam int DEF_SAMPLES_PER_LINE = 16;
    localparam int DEF_DATA_WIDTH       = DEF_SAMPLE_WIDTH * DEF_SAMPLES_PER_LINE + 1;
    localparam int DEF_BRAM_DEPTH       = 600;
    localparam int LAST_FLAG_BIT        = DEF_DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        ARMED = 2'd3
    } loader_state_t;

endpackage

// File: rtl/dense_wave_loader_packer.sv
// Slot buffer that packs consecutive samples into one BRAM line, lowest slot first.
module sample_line_packer
    import dense_loader_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
    parameter int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     push,
    input  logic [SAMPLE_WIDTH-1:0]                  data,
    output logic [SAMPLE_WIDTH*SAMPLES_PER_LINE-1:0] line,
    output logic                                     line_full
);

    localparam int SLOT_W = (SAMPLES_PER_LINE > 1) ? $clog2(SAMPLES_PER_LINE) : 1;

    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] base_slot;

    // A clear and a push in the same cycle start a fresh line with this sample in slot 0.
    assign base_slot = clear ? '0 : slot;
    assign line_full = push && (base_slot == SLOT_W'(SAMPLES_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
            slot <= '0;
        end else begin
            if (clear) begin
                line <= '0;
                slot <= '0;
            end
            if (push) begin
                line[base_slot*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= data;
                slot <= base_slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dense_wave_loader.sv
// Streams samples into packed BRAM lines and arms playback after the last line.
// Optional running-XOR checksum output when DENSE_LOADER_CHECKSUM_EN is defined.
module dense_wave_loader
    import dense_loader_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
    parameter int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE,
    parameter int DATA_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_LINE + 1,
    parameter int BRAM_DEPTH       = DEF_BRAM_DEPTH,
    localparam int AW              = $clog2(BRAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    input  logic                    write_rdy,
    output logic [AW-1:0]           addr,
    output logic [DATA_WIDTH-1:0]   line_out,
    output logic                    we,
    output logic                    en,
    output logic                    generator_mode,
    output logic                    rst_gen_mode,
    output logic [AW:0]             lines_written,
    output loader_state_t           state_dbg,
    output logic                    overflow
`ifdef DENSE_LOADER_CHECKSUM_EN
    ,
    output logic [SAMPLE_WIDTH-1:0] checksum
`endif
);

    loader_state_t state;
    logic          push;
    logic          line_full;
    logic          flag;
    logic          ovf_pend;
    logic          at_limit;
    logic [AW-1:0] base_addr;
    logic [SAMPLE_WIDTH*SAMPLES_PER_LINE-1:0] packed_line;

    // A sample transfers on a clock edge where s_valid && s_ready; s_ready is held low
    // while start is high so a sample is never consumed by a load that is being aborted.
    assign s_ready   = (state == FILL) && !start;
    assign push      = s_valid && s_ready;
    assign state_dbg = state;
    assign line_out  = {flag, packed_line};

    // Line buffer and address move on the cycle after we, so both stay stable while we is high.
    assign base_addr = (we && state == FILL) ? addr + 1'b1 : addr;
    assign at_limit  = (base_addr == AW'(BRAM_DEPTH - 1));

    sample_line_packer #(
        .SAMPLE_WIDTH     (SAMPLE_WIDTH),
        .SAMPLES_PER_LINE (SAMPLES_PER_LINE)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start || we),
        .push      (push),
        .data      (s_data),
        .line      (packed_line),
        .line_full (line_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            lines_written  <= '0;
            overflow       <= 1'b0;
            generator_mode <= 1'b0;
            rst_gen_mode   <= 1'b0;
            we             <= 1'b0;
            en             <= 1'b0;
            flag           <= 1'b0;
            ovf_pend       <= 1'b0;
        end else begin
            we           <= 1'b0;
            en           <= 1'b0;
            rst_gen_mode <= 1'b0;
            if (start) begin
                state          <= FILL;
                addr           <= '0;
                lines_written  <= '0;
                overflow       <= 1'b0;
                generator_mode <= 1'b0;
                rst_gen_mode   <= 1'b1;
                flag           <= 1'b0;
                ovf_pend       <= 1'b0;
            end else begin
                addr <= base_addr;
                case (state)
                    FILL: begin
                        if (push && (line_full || s_last)) begin
                            state    <= WRITE;
                            flag     <= s_last || at_limit;
                            ovf_pend <= at_limit && !s_last;
                        end
                    end
                    WRITE: begin
                        if (write_rdy) begin
                            we            <= 1'b1;
                            en            <= 1'b1;
                            lines_written <= lines_written + 1'b1;
                            if (flag) begin
                                state    <= ARMED;
                                overflow <= ovf_pend;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                    ARMED:   generator_mode <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef DENSE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum ^ s_data;
        end
    end
`endif

endmodule

// File: doc/dense_wave_loader.md
Name: dense_wave_loader

Overview:
- Upstream feeder for the dense waveform BRAM interface.
- Accepts a stream of DAC samples, packs SAMPLES_PER_LINE samples into one BRAM line, and writes lines sequentially from address 0, honouring the interface's write_rdy.
- Bit DATA_WIDTH-1 of each line is the last-line flag.
- When the final line is written, switches the interface into generator mode so playback can start.

Parameters:
- SAMPLE_WIDTH, 16, bits per sample.
- SAMPLES_PER_LINE, 16, samples packed per BRAM line.
- DATA_WIDTH, SAMPLE_WIDTH*SAMPLES_PER_LINE+1 (257), BRAM line width including the last-line flag.
- BRAM_DEPTH, 600, number of BRAM lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a new load at address 0.
- s_data  in  SAMPLE_WIDTH  input sample.
- s_valid  in  1  sample valid.
- s_last  in  1  marks the final sample of the waveform.
- s_ready  out  1  loader accepts a sample this cycle.
- write_rdy  in  1  from the BRAM interface; a write may be issued.
- addr  out  $clog2(BRAM_DEPTH)  BRAM write address.
- line_out  out  DATA_WIDTH  packed line to the BRAM.
- we  out  1  write enable.
- en  out  1  BRAM enable.
- generator_mode  out  1  playback enable to the BRAM interface.
- rst_gen_mode  out  1  single-cycle reset of the interface's playback pointer.
- lines_written  out  $clog2(BRAM_DEPTH)+1  count of lines committed in the current load.
- overflow  out  1  sticky; waveform exceeded BRAM_DEPTH lines.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE; packing buffer, slot counter and addr cleared.
- FSM states: IDLE, FILL, WRITE, ARMED.
- IDLE:
  - s_ready=0; samples are ignored.
  - start -> FILL next cycle. The same edge pulses rst_gen_mode for 1 cycle, clears addr, lines_written and overflow, and forces generator_mode=0.
- FILL:
  - s_ready=1. Each s_valid&&s_ready handshake stores s_data into bits [slot*SAMPLE_WIDTH +: SAMPLE_WIDTH] and increments slot.
  - Go to WRITE after the handshake that fills slot SAMPLES_PER_LINE-1, or after any handshake with s_last=1.
  - On s_last, unfilled slots are zero and the line flag = 1.
- WRITE:
  - s_ready=0. Hold line_out and addr stable.
  - On the first cycle with write_rdy=1: assert we=en=1 for exactly 1 cycle; increment lines_written; clear the buffer and slot.
  - Next state: ARMED if flag=1; otherwise FILL with addr+1.
  - If write_rdy is never high, the FSM waits indefinitely.
- Address limit: a line written at addr=BRAM_DEPTH-1 without s_last is forced to flag=1. Set overflow=1 and go to ARMED. Remaining input samples are never accepted.
- ARMED:
  - generator_mode=1 (registered; asserted the cycle after the final we). s_ready=0; we=en=0.
  - start -> same actions as from IDLE (re-load).
- start received in FILL or WRITE: abort the load. The partial line is discarded, no write is issued, and the loader restarts at addr 0 as if from IDLE.
- Latency: the final sample handshake -> we is asserted at earliest 1 cycle later (WRITE entered, write_rdy already high).
- Reset mid-load: immediate return to IDLE; no partial write is committed.
- Widths: slot is $clog2(SAMPLES_PER_LINE) bits; addr never wraps.

Optional Feature:
- Macro: DENSE_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [SAMPLE_WIDTH-1:0], the running XOR of all accepted samples.
  - Cleared on start and on rst; frozen in ARMED.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dense_loader_pkg:
  - loader_state_t enum {IDLE, FILL, WRITE, ARMED}.
  - LAST_FLAG_BIT = DATA_WIDTH-1.
  - Default SAMPLE_WIDTH / SAMPLES_PER_LINE constants.
- Sub-module sample_line_packer:
  - Holds the shift/slot buffer and slot counter.
  - Outputs line_full; clears on a pulse.
  - FSM and address logic stay in the top.

Test Plan:
- 32 samples 0..31, s_last on 31, write_rdy=1 -> 2 writes, at addr 0 and 1. Line 1 flag=1, line 0 flag=0. generator_mode=1 one cycle after the second we; lines_written=2.
- 5 samples, s_last on the 5th -> 1 write at addr 0 with slots 5..15 zero and flag=1; rst_gen_mode pulsed exactly once at start.
- write_rdy held low for 10 cycles after a full line -> we stays 0 and s_ready stays 0. we pulses 1 cycle after write_rdy rises, and line_out is unchanged throughout.
- 601*16 samples with no s_last, BRAM_DEPTH=600 -> 600 writes, last at addr 599 with flag forced to 1. overflow=1, s_ready=0 afterwards, generator_mode=1.
- start pulsed after 7 samples of line 3 -> no write for the partial line. Next write is at addr 0, and lines_written resets to 0.
- rst asserted while in WRITE -> we never asserted, and all outputs 0 the following cycle.
